// File: rtl/mat_pkg.sv
// Shared types and defaults for the row-organised complex matrix store.
package mat_pkg;
    localparam int SIZE_DEF  = 4;
    localparam int WIDTH_DEF = 64;

    // One complex element, imaginary part in the upper half.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] im;
        logic [WIDTH_DEF-1:0] re;
    } cplx_t;

    typedef cplx_t [SIZE_DEF-1:0] mat_row_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } srv_state_e;
endpackage

// File: rtl/row_store_ram.sv
// SIZE x row register array with a row-write port, a column-write port and two registered row read ports.
module row_store_ram #(
    parameter int SIZE  = 4,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         row_we,
    input  logic [AW-1:0]                row_addr,
    input  logic [SIZE-1:0][2*WIDTH-1:0] row_data,
    input  logic                         col_we,
    input  logic [AW-1:0]                col_addr,
    input  logic [SIZE-1:0][2*WIDTH-1:0] col_data,
    input  logic                         rd0_en,
    input  logic [AW-1:0]                rd0_addr,
    output logic [SIZE-1:0][2*WIDTH-1:0] rd0_data,
    input  logic [AW-1:0]                rd1_addr,
    output logic [SIZE-1:0][2*WIDTH-1:0] rd1_data
);
    localparam logic [AW:0] ROWS = (AW+1)'(SIZE);

    logic [SIZE-1:0][2*WIDTH-1:0] mem [SIZE];

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < ROWS;
    endfunction

    // Each row owns its own write logic; a column write touches one element of every row.
    for (genvar r = 0; r < SIZE; r++) begin : g_row
        always_ff @(posedge clk) begin
            if (row_we && row_addr == AW'(r)) begin
                mem[r] <= row_data;
            end
            if (col_we && in_range(col_addr)) begin
                mem[r][col_addr] <= col_data[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_data <= '0;
            rd1_data <= '0;
        end else begin
            if (rd0_en) begin
                rd0_data <= in_range(rd0_addr) ? mem[rd0_addr] : '0;
            end
            rd1_data <= in_range(rd1_addr) ? mem[rd1_addr] : '0;
        end
    end
endmodule

// File: rtl/mat_row_server.sv
// Row-organised complex matrix store serving the LU and triangular-inverse engines, plus a host load/unload port.
// Define READ_BYPASS_EN to make an engine read return the row as modified by a write in the same cycle.
module mat_row_server
    import mat_pkg::*;
#(
    parameter int  SIZE  = SIZE_DEF,
    parameter int  WIDTH = WIDTH_DEF,
    localparam int AW    = $clog2(SIZE),
    localparam int CW    = AW + $clog2(SIZE) + 1,
    localparam int RW    = SIZE * 2 * WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          done_i,
    output logic          active_o,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_addr_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_valid_o,
    input  logic [RW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic [RW-1:0] col_i,
    input  logic [AW-1:0] col_addr_i,
    input  logic          col_valid_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [RW-1:0] host_row_i,
    output logic [RW-1:0] host_row_o,
    output logic [CW-1:0] wr_count_o
);
    typedef logic [SIZE-1:0][2*WIDTH-1:0] row_t;

    srv_state_e    state, state_nx;
    logic          active, eng_en;
    logic          row_commit, col_commit, host_commit, rd_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    row_t          ram_data, ram_rd;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = ACTIVE;
            ACTIVE:  if (done_i)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Engine traffic is only honoured in ACTIVE, the host only writes in IDLE; the column wins over a row write.
    assign active      = (state == ACTIVE);
    assign eng_en      = active && !rst_i;
    assign wr_ready_o  = eng_en && !col_valid_i;
    assign row_commit  = wr_valid_i && wr_ready_o;
    assign col_commit  = col_valid_i && eng_en;
    assign host_commit = host_we_i && !active && !rst_i;
    assign rd_en       = rd_addr_valid_i && eng_en;
    assign active_o    = active;

    assign ram_we   = row_commit || host_commit;
    assign ram_addr = active ? wr_addr_i : host_addr_i;
    assign ram_data = active ? wr_row_i : host_row_i;

    row_store_ram #(.SIZE(SIZE), .WIDTH(WIDTH), .AW(AW)) u_store (
        .clk      (clk_i),
        .rst      (rst_i),
        .row_we   (ram_we),
        .row_addr (ram_addr),
        .row_data (ram_data),
        .col_we   (col_commit),
        .col_addr (col_addr_i),
        .col_data (col_i),
        .rd0_en   (rd_en),
        .rd0_addr (rd_addr_i),
        .rd0_data (ram_rd),
        .rd1_addr (host_addr_i),
        .rd1_data (host_row_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_addr_o  <= '0;
            wr_count_o <= '0;
        end else begin
            rd_valid_o <= rd_en;
            if (rd_en) begin
                rd_addr_o <= rd_addr_i;
            end
            if (!active && start_i) begin
                wr_count_o <= '0;
            end else if ((row_commit || col_commit) && wr_count_o != '1) begin
                wr_count_o <= wr_count_o + CW'(1);
            end
        end
    end

`ifdef READ_BYPASS_EN
    // The store hands back the pre-write row; record what the same-cycle write changed and patch it on output.
    localparam logic [AW:0] ROWS = (AW+1)'(SIZE);

    row_t               col_elems, byp_row_q, rd_row;
    logic               byp_row_hit_q, byp_col_hit_q;
    logic [AW-1:0]      byp_idx_q;
    logic [2*WIDTH-1:0] byp_elem_q;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < ROWS;
    endfunction

    assign col_elems = col_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byp_row_hit_q <= 1'b0;
            byp_col_hit_q <= 1'b0;
            byp_row_q     <= '0;
            byp_idx_q     <= '0;
            byp_elem_q    <= '0;
        end else if (rd_en) begin
            byp_row_hit_q <= row_commit && (wr_addr_i == rd_addr_i) && in_range(rd_addr_i);
            byp_col_hit_q <= col_commit && in_range(col_addr_i) && in_range(rd_addr_i);
            byp_row_q     <= wr_row_i;
            byp_idx_q     <= col_addr_i;
            byp_elem_q    <= col_elems[rd_addr_i];
        end
    end

    always_comb begin
        rd_row = ram_rd;
        if (byp_row_hit_q) begin
            rd_row = byp_row_q;
        end else if (byp_col_hit_q) begin
            rd_row[byp_idx_q] = byp_elem_q;
        end
    end

    assign rd_row_o = rd_row;
`else
    assign rd_row_o = ram_rd;
`endif
endmodule

// File: tb/tb_mat_row_server.sv
// Bench for mat_row_server: directed steps and random engine traffic checked every cycle against a behavioural matrix model.
module tb_mat_row_server;
    import mat_pkg::*;

    localparam int SIZE    = SIZE_DEF;
    localparam int WIDTH   = WIDTH_DEF;
    localparam int AW      = $clog2(SIZE);
    localparam int CW      = AW + $clog2(SIZE) + 1;
    localparam int RW      = SIZE * 2 * WIDTH;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, done = 1'b0;
    logic          rd_addr_valid = 1'b0, wr_valid = 1'b0, col_valid = 1'b0, host_we = 1'b0;
    logic [AW-1:0] rd_addr = '0, wr_addr = '0, col_addr = '0, host_addr = '0;
    mat_row_t      wr_row = '0, col_row = '0, host_row = '0;

    logic          active, rd_valid, wr_ready;
    logic [AW-1:0] rd_addr_q;
    mat_row_t      rd_row_q, host_row_q;
    logic [CW-1:0] wr_count;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model: the matrix itself plus the values each output should show.
    mat_row_t      m_mem [SIZE];
    bit            m_known [SIZE];
    bit            m_active, m_rd_valid, m_rd_known, m_host_known;
    logic [AW-1:0] m_rd_addr;
    mat_row_t      m_rd_row, m_host_row;
    int            m_cnt;

    mat_row_server dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .done_i          (done),
        .active_o        (active),
        .rd_addr_i       (rd_addr),
        .rd_addr_valid_i (rd_addr_valid),
        .rd_row_o        (rd_row_q),
        .rd_addr_o       (rd_addr_q),
        .rd_valid_o      (rd_valid),
        .wr_row_i        (wr_row),
        .wr_addr_i       (wr_addr),
        .wr_valid_i      (wr_valid),
        .wr_ready_o      (wr_ready),
        .col_i           (col_row),
        .col_addr_i      (col_addr),
        .col_valid_i     (col_valid),
        .host_we_i       (host_we),
        .host_addr_i     (host_addr),
        .host_row_i      (host_row),
        .host_row_o      (host_row_q),
        .wr_count_o      (wr_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [RW-1:0] observed, input logic [RW-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic mat_row_t rand_row();
        logic [RW-1:0] flat;
        for (int i = 0; i < RW / 32; i++) flat[i*32 +: 32] = $urandom;
        return mat_row_t'(flat);
    endfunction

    function automatic mat_row_t pattern_row(input int i);
        mat_row_t r;
        for (int j = 0; j < SIZE; j++) begin
            r[AW'(j)].re = $realtobits(real'(i * SIZE + j));
            r[AW'(j)].im = $realtobits(-real'(i * SIZE + j));
        end
        return r;
    endfunction

    task automatic clearInputs();
        start         = 1'b0;
        done          = 1'b0;
        rd_addr_valid = 1'b0;
        wr_valid      = 1'b0;
        col_valid     = 1'b0;
        host_we       = 1'b0;
    endtask

    // One clock cycle: check the handshake, advance the model from the current inputs, then check registered outputs.
    task automatic applyStimulus();
        mat_row_t old_mem [SIZE];
        bit       old_known [SIZE];
        bit       act;
        #1;
        act = m_active;
        checkOutput("wr_ready", RW'(wr_ready), RW'(act && !rst && !col_valid));
        old_mem   = m_mem;
        old_known = m_known;
        if (rst) begin
            m_active     = 1'b0;
            m_rd_valid   = 1'b0;
            m_rd_addr    = '0;
            m_rd_row     = '0;
            m_rd_known   = 1'b1;
            m_host_row   = '0;
            m_host_known = 1'b1;
            m_cnt        = 0;
        end else begin
            m_host_row   = old_mem[host_addr];
            m_host_known = old_known[host_addr];
            if (act && rd_addr_valid) begin
                m_rd_addr  = rd_addr;
                m_rd_row   = old_mem[rd_addr];
                m_rd_known = old_known[rd_addr];
            end
            m_rd_valid = act && rd_addr_valid;
            if (!act && host_we) begin
                m_mem[host_addr]   = host_row;
                m_known[host_addr] = 1'b1;
            end
            if (act && col_valid) begin
                for (int k = 0; k < SIZE; k++) m_mem[k][col_addr] = col_row[AW'(k)];
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (act && wr_valid) begin
                m_mem[wr_addr]   = wr_row;
                m_known[wr_addr] = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end
`ifdef READ_BYPASS_EN
            if (act && rd_addr_valid) begin
                m_rd_row   = m_mem[rd_addr];
                m_rd_known = m_known[rd_addr];
            end
`endif
            if (!act && start) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end else if (act && done) begin
                m_active = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("active", RW'(active), RW'(m_active));
        checkOutput("rd_valid", RW'(rd_valid), RW'(m_rd_valid));
        checkOutput("rd_addr", RW'(rd_addr_q), RW'(m_rd_addr));
        if (m_rd_known) checkOutput("rd_row", RW'(rd_row_q), RW'(m_rd_row));
        if (m_host_known) checkOutput("host_row", RW'(host_row_q), RW'(m_host_row));
        checkOutput("wr_count", RW'(wr_count), RW'(m_cnt));
    endtask

    initial begin
        mat_row_t      one_row, col_pat, new_row, saved_row, hr;
        cplx_t         elem;
        logic [AW-1:0] seq [3];

        $display("[TB] mat_row_server bench starting");

        // Reset: every output is zero.
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_count", RW'(wr_count), RW'(0));
        rst = 1'b0;

        // Host loads the reference pattern, then reads row 2 back.
        for (int i = 0; i < SIZE; i++) begin
            host_we   = 1'b1;
            host_addr = AW'(i);
            host_row  = pattern_row(i);
            applyStimulus();
        end
        clearInputs();
        host_addr = AW'(2);
        applyStimulus();
        elem.re = $realtobits(9.0);
        elem.im = $realtobits(-9.0);
        checkOutput("host_elem_2_1", RW'(host_row_q[1]), RW'(elem));

        // Hand over to the engine and stream three reads.
        start = 1'b1;
        applyStimulus();
        clearInputs();
        seq = '{AW'(3), AW'(0), AW'(1)};
        foreach (seq[i]) begin
            rd_addr_valid = 1'b1;
            rd_addr       = seq[i];
            applyStimulus();
        end
        clearInputs();
        applyStimulus();

        // Row write to 1 collides with column write to 2: column first, row stalls one cycle.
        for (int j = 0; j < SIZE; j++) begin
            one_row[AW'(j)].re = $realtobits(1.0);
            one_row[AW'(j)].im = '0;
            col_pat[AW'(j)].re = $realtobits(real'(j));
            col_pat[AW'(j)].im = $realtobits(real'(j));
        end
        wr_valid  = 1'b1;
        wr_addr   = AW'(1);
        wr_row    = one_row;
        col_valid = 1'b1;
        col_addr  = AW'(2);
        col_row   = col_pat;
        #1;
        checkOutput("wr_ready_stall", RW'(wr_ready), RW'(0));
        applyStimulus();
        col_valid = 1'b0;
        applyStimulus();
        clearInputs();
        checkOutput("wr_count_two", RW'(wr_count), RW'(2));
        rd_addr_valid = 1'b1;
        rd_addr       = AW'(3);
        applyStimulus();
        clearInputs();
        elem.re = $realtobits(3.0);
        elem.im = $realtobits(3.0);
        checkOutput("col_landed_3_2", RW'(rd_row_q[2]), RW'(elem));

        // Same-cycle read and write of row 1.
        new_row       = rand_row();
        wr_valid      = 1'b1;
        wr_addr       = AW'(1);
        wr_row        = new_row;
        rd_addr_valid = 1'b1;
        rd_addr       = AW'(1);
        applyStimulus();
        clearInputs();
`ifdef READ_BYPASS_EN
        checkOutput("same_cycle_rw", RW'(rd_row_q), RW'(new_row));
`else
        checkOutput("same_cycle_rw", RW'(rd_row_q), RW'(one_row));
`endif

        // Same-cycle read of row 0 and column write to column 1.
        col_valid     = 1'b1;
        col_addr      = AW'(1);
        col_row       = rand_row();
        rd_addr_valid = 1'b1;
        rd_addr       = AW'(0);
        applyStimulus();
        clearInputs();

        // Random engine traffic, long enough to saturate the write counter.
        for (int n = 0; n < 60; n++) begin
            rd_addr_valid = 1'($urandom_range(0, 1));
            rd_addr       = AW'($urandom_range(0, SIZE - 1));
            wr_valid      = ($urandom_range(0, 3) != 0);
            wr_addr       = AW'($urandom_range(0, SIZE - 1));
            wr_row        = rand_row();
            col_valid     = ($urandom_range(0, 2) == 0);
            col_addr      = AW'($urandom_range(0, SIZE - 1));
            col_row       = rand_row();
            applyStimulus();
        end
        clearInputs();

        // Host write and start are ignored while ACTIVE.
        saved_row = m_mem[0];
        host_we   = 1'b1;
        host_addr = AW'(0);
        host_row  = rand_row();
        start     = 1'b1;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("host_we_ignored", RW'(host_row_q), RW'(saved_row));

        // done returns to IDLE, then the host write lands.
        done = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("done_idle", RW'(active), RW'(0));
        hr        = rand_row();
        host_we   = 1'b1;
        host_addr = AW'(0);
        host_row  = hr;
        applyStimulus();
        clearInputs();
        applyStimulus();
        checkOutput("host_write_idle", RW'(host_row_q), RW'(hr));

        // start and done together: start wins in IDLE, done wins in ACTIVE.
        start = 1'b1;
        done  = 1'b1;
        applyStimulus();
        applyStimulus();
        clearInputs();

        // Reset in ACTIVE drops the outstanding read and keeps the matrix.
        start = 1'b1;
        applyStimulus();
        clearInputs();
        rd_addr_valid = 1'b1;
        rd_addr       = AW'(2);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        clearInputs();
        checkOutput("rst_drops_read", RW'(rd_valid), RW'(0));
        checkOutput("rst_idle", RW'(active), RW'(0));
        rst = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            host_addr = AW'(i);
            applyStimulus();
        end
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
